// File: rtl/hd63701_exec_pkg.sv
// hd63701_exec_w shared definitions: op codes, selector codes,
// address modes, branch conditions, CCR bit positions and reset value.
package hd63701_exec_pkg;

    typedef enum logic [4:0] {
        OP_MOV = 5'd0,
        OP_ADD = 5'd1,
        OP_ADC = 5'd2,
        OP_SUB = 5'd3,
        OP_SBC = 5'd4,
        OP_AND = 5'd5,
        OP_OR  = 5'd6,
        OP_XOR = 5'd7,
        OP_INC = 5'd8,
        OP_DEC = 5'd9,
        OP_NEG = 5'd10,
        OP_COM = 5'd11,
        OP_PSH = 5'd12,
        OP_PUL = 5'd13,
        OP_BRA = 5'd14,
        OP_LDV = 5'd15,
        OP_INT = 5'd16,
        OP_NOP = 5'd17
    } op_e;

    localparam logic [3:0] SEL_NONE = 4'd0;
    localparam logic [3:0] SEL_C    = 4'd1;
    localparam logic [3:0] SEL_X    = 4'd2;
    localparam logic [3:0] SEL_S    = 4'd3;
    localparam logic [3:0] SEL_P    = 4'd4;
    localparam logic [3:0] SEL_T    = 4'd5;
    localparam logic [3:0] SEL_E    = 4'd6;
    localparam logic [3:0] SEL_M    = 4'd7;
    localparam logic [3:0] SEL_A0   = 4'd8;

    typedef enum logic [2:0] {
        AM_NONE = 3'd0,
        AM_P    = 3'd1,
        AM_P1   = 3'd2,
        AM_S    = 3'd3,
        AM_S1   = 3'd4,
        AM_X    = 3'd5,
        AM_XT   = 3'd6,
        AM_E    = 3'd7
    } am_e;

    typedef enum logic [3:0] {
        CC_RA, CC_RN, CC_HI, CC_LS,
        CC_CC, CC_CS, CC_NE, CC_EQ,
        CC_VC, CC_VS, CC_PL, CC_MI,
        CC_GE, CC_LT, CC_GT, CC_LE
    } cc_e;

    localparam int CCR_C = 0;
    localparam int CCR_V = 1;
    localparam int CCR_Z = 2;
    localparam int CCR_N = 3;
    localparam int CCR_I = 4;
    localparam int CCR_H = 5;

    localparam logic [5:0] CCR_RESET = 6'b010000;

    // Conditions come in pairs: odd code is the inverse of the even one.
    function automatic logic cond_true(input logic [3:0] cc,
                                       input logic [5:0] ccr);
        logic c, v, z, n, base;
        c = ccr[CCR_C];
        v = ccr[CCR_V];
        z = ccr[CCR_Z];
        n = ccr[CCR_N];
        case (cc[3:1])
            3'd0:    base = 1'b1;
            3'd1:    base = ~(c | z);
            3'd2:    base = ~c;
            3'd3:    base = ~z;
            3'd4:    base = ~v;
            3'd5:    base = ~n;
            3'd6:    base = ~(n ^ v);
            default: base = ~(z | (n ^ v));
        endcase
        return base ^ cc[0];
    endfunction

endpackage

// File: rtl/hd63701_exec_w_alu.sv
// Combinational ALU: result and CCR update for one microcode step.
// Ports: op, narrow (DW-wide op), a/b operands, ccr_in -> res, ccr_out.
module hd63701_alu_w
    import hd63701_exec_pkg::*;
#(
    parameter int DW = 8
) (
    input  op_e         op,
    input  logic        narrow,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [5:0]  ccr_in,
    output logic [15:0] res,
    output logic [5:0]  ccr_out
);

    localparam logic [16:0] NMASK = 17'((17'd1 << DW) - 17'd1);

    logic [16:0] mask;
    logic [16:0] ax;
    logic [16:0] bx;
    logic [16:0] s;
    logic        is_add;
    logic        is_sub;
    logic        is_log;
    logic        msb_a;
    logic        msb_b;
    logic        msb_r;
    logic        cout;
    logic        ovf;

    always_comb begin
        mask   = narrow ? NMASK : 17'h0ffff;
        ax     = {1'b0, a} & mask;
        bx     = {1'b0, b} & mask;
        s      = ax;
        is_add = 1'b0;
        is_sub = 1'b0;
        is_log = 1'b0;
        unique case (op)
            OP_ADD: begin
                s = ax + bx;
                is_add = 1'b1;
            end
            OP_ADC: begin
                s = ax + bx + {16'd0, ccr_in[CCR_C]};
                is_add = 1'b1;
            end
            OP_SUB: begin
                s = ax - bx;
                is_sub = 1'b1;
            end
            OP_SBC: begin
                s = ax - bx - {16'd0, ccr_in[CCR_C]};
                is_sub = 1'b1;
            end
            OP_INC: begin
                bx = 17'd1;
                s = ax + bx;
                is_add = 1'b1;
            end
            OP_DEC: begin
                bx = 17'd1;
                s = ax - bx;
                is_sub = 1'b1;
            end
            OP_NEG: begin
                bx = ax;
                ax = 17'd0;
                s = ax - bx;
                is_sub = 1'b1;
            end
            OP_AND: begin
                s = ax & bx;
                is_log = 1'b1;
            end
            OP_OR: begin
                s = ax | bx;
                is_log = 1'b1;
            end
            OP_XOR: begin
                s = ax ^ bx;
                is_log = 1'b1;
            end
            OP_COM: begin
                s = ~ax;
                is_log = 1'b1;
            end
            default: s = ax;
        endcase

        res   = s[15:0] & mask[15:0];
        msb_a = narrow ? ax[DW-1] : ax[15];
        msb_b = narrow ? bx[DW-1] : bx[15];
        msb_r = narrow ? res[DW-1] : res[15];
        // Operands are masked, so bit DW of the raw sum is carry/borrow.
        cout  = narrow ? s[DW] : s[16];
        ovf   = is_add ? ((msb_a == msb_b) && (msb_r != msb_a))
                       : ((msb_a != msb_b) && (msb_r != msb_a));

        ccr_out = ccr_in;
        if (is_add || is_sub) begin
            ccr_out[CCR_N] = msb_r;
            ccr_out[CCR_Z] = (res == 16'd0);
            ccr_out[CCR_V] = ovf;
            ccr_out[CCR_C] = cout;
            if (DW == 8)
                ccr_out[CCR_H] = ax[4] ^ bx[4] ^ s[4];
        end else if (is_log) begin
            ccr_out[CCR_N] = msb_r;
            ccr_out[CCR_Z] = (res == 16'd0);
            ccr_out[CCR_V] = 1'b0;
        end
    end

endmodule

// File: rtl/hd63701_exec_w.sv
// HD63701 microcode execution unit with bus wait-state handshake.
// Ports: CLK/RST_N, mc_* step in, mc_ack, AD/RW/DO/DI/mem_req/mem_rdy bus,
// vect/inte, REG_X/S/P/C debug taps.
module hd63701_exec_w
    import hd63701_exec_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          mc_valid,
    input  logic [4:0]    mc_op,
    input  logic [3:0]    mc_r0,
    input  logic [3:0]    mc_r1,
    input  logic [3:0]    mc_r2,
    input  logic [2:0]    mc_am,
    input  logic          mc_pi,
    output logic          mc_ack,
    output logic [15:0]   AD,
    output logic          RW,
    output logic [DW-1:0] DO,
    input  logic [DW-1:0] DI,
    output logic          mem_req,
    input  logic          mem_rdy,
    output logic [7:0]    vect,
    output logic          inte,
    output logic [15:0]   REG_X,
    output logic [15:0]   REG_S,
    output logic [15:0]   REG_P,
    output logic [5:0]    REG_C
);

    logic [DW-1:0] acc [NREG];
    logic [15:0]   x_q;
    logic [15:0]   s_q;
    logic [15:0]   p_q;
    logic [15:0]   t_q;
    logic [15:0]   e_q;
    logic [5:0]    c_q;
    logic [7:0]    vect_q;

    op_e           op;
    logic [15:0]   src0;
    logic [15:0]   src1;
    logic [15:0]   alu_a;
    logic [15:0]   alu_res;
    logic [5:0]    alu_ccr;
    logic [15:0]   ea;
    logic [15:0]   p_inc;
    logic [15:0]   p_next;
    logic          narrow;
    logic          req_raw;
    logic          do_wr;
    logic          set_flags;
    logic          taken;

    function automatic logic is_narrow(input logic [3:0] sel);
        return (sel == SEL_M) ||
               (sel[3] && (int'(sel[2:0]) < NREG));
    endfunction

    function automatic logic [15:0] sel_read(input logic [3:0] sel);
        logic [15:0] v;
        v = 16'd0;
        unique case (sel)
            SEL_C:   v = {10'd0, c_q};
            SEL_X:   v = x_q;
            SEL_S:   v = s_q;
            SEL_P:   v = p_q;
            SEL_T:   v = t_q;
            SEL_E:   v = e_q;
            SEL_M:   v = 16'(DI);
            default: begin
                for (int k = 0; k < NREG; k++)
                    if (sel == 4'(8 + k))
                        v = 16'(acc[k]);
            end
        endcase
        return v;
    endfunction

    assign op = op_e'(mc_op);

    always_comb begin
        src0      = sel_read(mc_r0);
        src1      = sel_read(mc_r1);
        // PUL always takes the bus word regardless of r0.
        alu_a     = (op == OP_PUL) ? 16'(DI) : src0;
        narrow    = is_narrow(mc_r0) || is_narrow(mc_r1) ||
                    is_narrow(mc_r2) ||
                    (op == OP_PUL) || (op == OP_PSH);
        do_wr     = op inside {OP_MOV, OP_ADD, OP_ADC, OP_SUB,
                               OP_SBC, OP_AND, OP_OR, OP_XOR,
                               OP_INC, OP_DEC, OP_NEG, OP_COM,
                               OP_PSH, OP_PUL};
        set_flags = (op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC,
                                OP_AND, OP_OR, OP_XOR, OP_INC,
                                OP_DEC, OP_NEG, OP_COM}) &&
                    !(mc_r2 inside {SEL_C, SEL_S, SEL_P});
        taken     = (op == OP_BRA) && cond_true(mc_r0, c_q);
    end

    hd63701_alu_w #(
        .DW(DW)
    ) u_alu (
        .op     (op),
        .narrow (narrow),
        .a      (alu_a),
        .b      (src1),
        .ccr_in (c_q),
        .res    (alu_res),
        .ccr_out(alu_ccr)
    );

    always_comb begin
        ea = 16'd0;
        unique case (mc_am)
            AM_P:    ea = p_q;
            AM_P1:   ea = p_q + 16'd1;
            AM_S:    ea = s_q;
            AM_S1:   ea = s_q + 16'd1;
            AM_X:    ea = x_q;
            AM_XT:   ea = x_q + t_q;
            AM_E:    ea = e_q;
            default: ea = 16'd0;
        endcase
    end

    // Branch offset is added on top of the mc_pi increment.
    assign p_inc  = p_q + {15'd0, mc_pi};
    assign p_next = taken ? p_inc + {{8{t_q[7]}}, t_q[7:0]} : p_inc;

    // Bus outputs are gated by RST_N so they drop the moment reset asserts.
    assign req_raw = mc_valid && (mc_am != AM_NONE);
    assign mem_req = RST_N && req_raw;
    assign RW      = mem_req && (mc_r2 == SEL_M);
    assign AD      = mem_req ? ea : 16'd0;
    assign DO      = RST_N ? alu_res[DW-1:0] : '0;
    assign mc_ack  = RST_N && mc_valid && (!req_raw || mem_rdy);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < NREG; k++)
                acc[k] <= '0;
            x_q    <= 16'd0;
            s_q    <= 16'd0;
            p_q    <= 16'd0;
            t_q    <= 16'd0;
            e_q    <= 16'd0;
            c_q    <= CCR_RESET;
            vect_q <= 8'd0;
        end else if (mc_ack) begin
            p_q <= p_next;
            if (op == OP_PSH)
                s_q <= s_q - 16'd1;
            if (op == OP_PUL)
                s_q <= s_q + 16'd1;
            if (op == OP_LDV)
                e_q <= {8'hFF, mc_r0, mc_r1};
            if (op == OP_INT)
                vect_q <= {mc_r0, mc_r1};
            if (set_flags)
                c_q <= alu_ccr;
            // Explicit destination writes land last and win.
            if (do_wr) begin
                unique case (mc_r2)
                    SEL_C:   c_q <= alu_res[5:0];
                    SEL_X:   x_q <= alu_res;
                    SEL_S:   s_q <= alu_res;
                    SEL_P:   p_q <= alu_res;
                    SEL_T:   t_q <= alu_res;
                    SEL_E:   e_q <= alu_res;
                    default: begin
                        for (int k = 0; k < NREG; k++)
                            if (mc_r2 == 4'(8 + k))
                                acc[k] <= alu_res[DW-1:0];
                    end
                endcase
            end
        end
    end

    assign vect  = vect_q;
    assign inte  = ~c_q[CCR_I];
    assign REG_X = x_q;
    assign REG_S = s_q;
    assign REG_P = p_q;
    assign REG_C = c_q;

endmodule

// File: tb/tb_hd63701_exec_w.sv
// Directed self-checking bench for hd63701_exec_w (DW=8, NREG=2).
// Accumulators are observed by moving them into X.
module tb_hd63701_exec_w;
    import hd63701_exec_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic        mc_valid;
    logic [4:0]  mc_op;
    logic [3:0]  mc_r0;
    logic [3:0]  mc_r1;
    logic [3:0]  mc_r2;
    logic [2:0]  mc_am;
    logic        mc_pi;
    logic        mc_ack;
    logic [15:0] AD;
    logic        RW;
    logic [7:0]  DO;
    logic [7:0]  DI;
    logic        mem_req;
    logic        mem_rdy;
    logic [7:0]  vect;
    logic        inte;
    logic [15:0] REG_X;
    logic [15:0] REG_S;
    logic [15:0] REG_P;
    logic [5:0]  REG_C;

    int tests;
    int failed;

    localparam logic [3:0] A0 = 4'd8;
    localparam logic [3:0] A1 = 4'd9;

    hd63701_exec_w #(.DW(8), .NREG(2)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .mc_valid(mc_valid), .mc_op(mc_op),
        .mc_r0(mc_r0), .mc_r1(mc_r1), .mc_r2(mc_r2),
        .mc_am(mc_am), .mc_pi(mc_pi), .mc_ack(mc_ack),
        .AD(AD), .RW(RW), .DO(DO), .DI(DI),
        .mem_req(mem_req), .mem_rdy(mem_rdy),
        .vect(vect), .inte(inte),
        .REG_X(REG_X), .REG_S(REG_S), .REG_P(REG_P), .REG_C(REG_C)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic drive(input logic [4:0] op, input logic [3:0] r0,
                         input logic [3:0] r1, input logic [3:0] r2,
                         input logic [2:0] am, input logic pi);
        mc_valid = 1'b1;
        mc_op = op;
        mc_r0 = r0;
        mc_r1 = r1;
        mc_r2 = r2;
        mc_am = am;
        mc_pi = pi;
        mem_rdy = 1'b1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input logic [4:0] op, input logic [3:0] r0,
                        input logic [3:0] r1, input logic [3:0] r2,
                        input logic [2:0] am, input logic pi);
        drive(op, r0, r1, r2, am, pi);
        tick();
    endtask

    task automatic load_acc(input logic [3:0] a, input logic [7:0] v);
        DI = v;
        step(OP_MOV, SEL_M, SEL_NONE, a, AM_X, 1'b0);
    endtask

    // Builds a 16-bit value in X by shift (X+X) and increment.
    task automatic set_x(input logic [15:0] v);
        step(OP_MOV, SEL_NONE, SEL_NONE, SEL_X, AM_NONE, 1'b0);
        for (int i = 15; i >= 0; i--) begin
            step(OP_ADD, SEL_X, SEL_X, SEL_X, AM_NONE, 1'b0);
            if (v[i])
                step(OP_INC, SEL_X, SEL_NONE, SEL_X, AM_NONE, 1'b0);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        drive(OP_MOV, SEL_M, SEL_NONE, SEL_M, AM_X, 1'b0);
        tick();
        tests++;
        if (REG_C !== 6'h10) begin
            failed++;
            $display("FAIL reset_c: got %h want 10", REG_C);
        end
        tests++;
        if (inte !== 1'b0) begin
            failed++;
            $display("FAIL reset_inte: got %b want 0", inte);
        end
        tests++;
        if ({REG_X, REG_S, REG_P} !== 48'd0) begin
            failed++;
            $display("FAIL reset_regs: got %h %h %h want 0",
                     REG_X, REG_S, REG_P);
        end
        tests++;
        if ({mc_ack, mem_req, RW, AD, DO, vect} !== 35'd0) begin
            failed++;
            $display("FAIL reset_bus: ack%b req%b rw%b ad%h do%h v%h want 0",
                     mc_ack, mem_req, RW, AD, DO, vect);
        end
        RST_N = 1'b1;
        drive(OP_MOV, SEL_NONE, SEL_NONE, SEL_C, AM_NONE, 1'b0);
        #1;
        tests++;
        if (mc_ack !== 1'b1) begin
            failed++;
            $display("FAIL first_ack: got %b want 1", mc_ack);
        end
        @(posedge CLK);
        #1;
        tests++;
        if (REG_C !== 6'h00 || inte !== 1'b1) begin
            failed++;
            $display("FAIL mov_c: got c=%h inte=%b want 00 1", REG_C, inte);
        end
    endtask

    task automatic test_add();
        load_acc(A0, 8'h7F);
        load_acc(A1, 8'h01);
        step(OP_ADD, A0, A1, A0, AM_NONE, 1'b0);
        tests++;
        if (REG_C !== 6'h2A) begin
            failed++;
            $display("FAIL add_flags: got %h want 2a", REG_C);
        end
        step(OP_MOV, A0, SEL_NONE, SEL_X, AM_NONE, 1'b0);
        tests++;
        if (REG_X !== 16'h0080) begin
            failed++;
            $display("FAIL add_res: got %h want 0080", REG_X);
        end
        load_acc(A0, 8'hFF);
        step(OP_ADD, A0, A1, A0, AM_NONE, 1'b0);
        tests++;
        if (REG_C !== 6'h25) begin
            failed++;
            $display("FAIL add_carry_flags: got %h want 25", REG_C);
        end
    endtask

    task automatic test_sub_logic();
        load_acc(A0, 8'h00);
        step(OP_SUB, A0, A1, A0, AM_NONE, 1'b0);
        tests++;
        if (REG_C !== 6'h29) begin
            failed++;
            $display("FAIL sub_flags: got %h want 29", REG_C);
        end
        step(OP_MOV, A0, SEL_NONE, SEL_X, AM_NONE, 1'b0);
        tests++;
        if (REG_X !== 16'h00FF) begin
            failed++;
            $display("FAIL sub_res: got %h want 00ff", REG_X);
        end
        load_acc(A0, 8'hF0);
        load_acc(A1, 8'h3C);
        step(OP_AND, A0, A1, A0, AM_NONE, 1'b0);
        tests++;
        if (REG_C !== 6'h21) begin
            failed++;
            $display("FAIL and_flags: got %h want 21", REG_C);
        end
        step(OP_MOV, A0, SEL_NONE, SEL_X, AM_NONE, 1'b0);
        tests++;
        if (REG_X !== 16'h0030) begin
            failed++;
            $display("FAIL and_res: got %h want 0030", REG_X);
        end
    endtask

    task automatic test_mem_wait();
        set_x(16'h1234);
        drive(OP_MOV, SEL_M, SEL_NONE, A0, AM_X, 1'b1);
        for (int i = 0; i < 3; i++) begin
            mem_rdy = 1'b0;
            DI = 8'h11;
            #1;
            tests++;
            if (AD !== 16'h1234 || mem_req !== 1'b1 ||
                mc_ack !== 1'b0 || RW !== 1'b0) begin
                failed++;
                $display("FAIL wait_%0d: ad%h req%b ack%b rw%b want 1234 1 0 0",
                         i, AD, mem_req, mc_ack, RW);
            end
            tick();
            tests++;
            if (REG_P !== 16'h0000) begin
                failed++;
                $display("FAIL wait_hold_p: got %h want 0000", REG_P);
            end
        end
        mem_rdy = 1'b1;
        DI = 8'hA5;
        #1;
        tests++;
        if (AD !== 16'h1234 || mc_ack !== 1'b1) begin
            failed++;
            $display("FAIL wait_done: ad%h ack%b want 1234 1", AD, mc_ack);
        end
        tick();
        tests++;
        if (REG_P !== 16'h0001) begin
            failed++;
            $display("FAIL wait_pi: got %h want 0001", REG_P);
        end
        DI = 8'h00;
        step(OP_MOV, A0, SEL_NONE, SEL_X, AM_NONE, 1'b0);
        tests++;
        if (REG_X !== 16'h00A5) begin
            failed++;
            $display("FAIL wait_data: got %h want 00a5", REG_X);
        end
    endtask

    task automatic test_push_pull();
        set_x(16'h01FF);
        step(OP_MOV, SEL_X, SEL_NONE, SEL_S, AM_NONE, 1'b0);
        load_acc(A1, 8'h5A);
        drive(OP_PSH, A1, SEL_NONE, SEL_M, AM_S, 1'b0);
        #1;
        tests++;
        if (AD !== 16'h01FF || RW !== 1'b1 || DO !== 8'h5A ||
            mc_ack !== 1'b1) begin
            failed++;
            $display("FAIL psh_bus: ad%h rw%b do%h ack%b want 01ff 1 5a 1",
                     AD, RW, DO, mc_ack);
        end
        @(posedge CLK);
        #1;
        tests++;
        if (REG_S !== 16'h01FE) begin
            failed++;
            $display("FAIL psh_s: got %h want 01fe", REG_S);
        end
        DI = 8'h5A;
        drive(OP_PUL, SEL_NONE, SEL_NONE, A0, AM_S1, 1'b0);
        #1;
        tests++;
        if (AD !== 16'h01FF || RW !== 1'b0) begin
            failed++;
            $display("FAIL pul_bus: ad%h rw%b want 01ff 0", AD, RW);
        end
        @(posedge CLK);
        #1;
        tests++;
        if (REG_S !== 16'h01FF) begin
            failed++;
            $display("FAIL pul_s: got %h want 01ff", REG_S);
        end
        DI = 8'h00;
        step(OP_MOV, A0, SEL_NONE, SEL_X, AM_NONE, 1'b0);
        tests++;
        if (REG_X !== 16'h005A) begin
            failed++;
            $display("FAIL pul_data: got %h want 005a", REG_X);
        end
    endtask

    task automatic test_bra();
        set_x(16'h00FE);
        step(OP_MOV, SEL_X, SEL_NONE, SEL_T, AM_NONE, 1'b0);
        set_x(16'h1000);
        step(OP_MOV, SEL_X, SEL_NONE, SEL_P, AM_NONE, 1'b0);
        set_x(16'h0004);
        step(OP_MOV, SEL_X, SEL_NONE, SEL_C, AM_NONE, 1'b0);
        step(OP_BRA, CC_EQ, SEL_NONE, SEL_NONE, AM_NONE, 1'b1);
        tests++;
        if (REG_P !== 16'h0FFF) begin
            failed++;
            $display("FAIL bra_taken: got %h want 0fff", REG_P);
        end
        set_x(16'h1000);
        step(OP_MOV, SEL_X, SEL_NONE, SEL_P, AM_NONE, 1'b0);
        step(OP_MOV, SEL_NONE, SEL_NONE, SEL_C, AM_NONE, 1'b0);
        step(OP_BRA, CC_EQ, SEL_NONE, SEL_NONE, AM_NONE, 1'b1);
        tests++;
        if (REG_P !== 16'h1001) begin
            failed++;
            $display("FAIL bra_not_taken: got %h want 1001", REG_P);
        end
        drive(5'd31, SEL_NONE, SEL_NONE, SEL_X, AM_NONE, 1'b1);
        #1;
        tests++;
        if (mc_ack !== 1'b1) begin
            failed++;
            $display("FAIL unk_ack: got %b want 1", mc_ack);
        end
        @(posedge CLK);
        #1;
        tests++;
        if (REG_P !== 16'h1002 || REG_X !== 16'h1000) begin
            failed++;
            $display("FAIL unk_nop: p%h x%h want 1002 1000", REG_P, REG_X);
        end
    endtask

    task automatic test_ldv_int();
        step(OP_LDV, 4'hA, 4'hB, SEL_NONE, AM_NONE, 1'b0);
        step(OP_MOV, SEL_E, SEL_NONE, SEL_X, AM_NONE, 1'b0);
        tests++;
        if (REG_X !== 16'hFFAB) begin
            failed++;
            $display("FAIL ldv: got %h want ffab", REG_X);
        end
        step(OP_INT, 4'h3, 4'hC, SEL_NONE, AM_NONE, 1'b0);
        tests++;
        if (vect !== 8'h3C) begin
            failed++;
            $display("FAIL int_vect: got %h want 3c", vect);
        end
    endtask

    task automatic test_reset_stall();
        drive(OP_PSH, A1, SEL_NONE, SEL_M, AM_S, 1'b1);
        mem_rdy = 1'b0;
        #1;
        tests++;
        if (RW !== 1'b1 || mem_req !== 1'b1 || mc_ack !== 1'b0) begin
            failed++;
            $display("FAIL stall_wr: rw%b req%b ack%b want 1 1 0",
                     RW, mem_req, mc_ack);
        end
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        tests++;
        if (RW !== 1'b0 || mem_req !== 1'b0 || mc_ack !== 1'b0 ||
            AD !== 16'd0 || DO !== 8'd0) begin
            failed++;
            $display("FAIL rst_bus: rw%b req%b ack%b ad%h do%h want 0",
                     RW, mem_req, mc_ack, AD, DO);
        end
        tests++;
        if (REG_S !== 16'd0 || REG_P !== 16'd0 || REG_X !== 16'd0 ||
            REG_C !== 6'h10 || vect !== 8'd0) begin
            failed++;
            $display("FAIL rst_regs: s%h p%h x%h c%h v%h want 0 0 0 10 0",
                     REG_S, REG_P, REG_X, REG_C, vect);
        end
        mc_valid = 1'b0;
        tick();
        RST_N = 1'b1;
        load_acc(A0, 8'h77);
        step(OP_MOV, A1, SEL_NONE, SEL_X, AM_NONE, 1'b0);
        tests++;
        if (REG_X !== 16'h0000 || REG_S !== 16'h0000) begin
            failed++;
            $display("FAIL rst_acc: x%h s%h want 0000 0000", REG_X, REG_S);
        end
    endtask

    initial begin
        tests = 0;
        failed = 0;
        RST_N = 1'b0;
        mc_valid = 1'b0;
        mc_op = 5'd0;
        mc_r0 = 4'd0;
        mc_r1 = 4'd0;
        mc_r2 = 4'd0;
        mc_am = 3'd0;
        mc_pi = 1'b0;
        DI = 8'd0;
        mem_rdy = 1'b1;
        test_reset();
        test_add();
        test_sub_logic();
        test_mem_wait();
        test_push_pull();
        test_bra();
        test_ldv_int();
        test_reset_stall();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/hd63701_exec_w.md
# hd63701_exec_w

Parametrised, wait-state-capable successor to the HD63701 microcode execution unit. It executes one microcode step per accepted cycle against a configurable accumulator bank (count and data width), a fixed 16-bit index, stack, program counter, temp and effective-address register set, and a 6-bit CCR. Unlike the single-cycle original, every memory step handshakes with the bus through `mem_req`/`mem_rdy` and stalls the sequencer via `mc_ack`. It sits between the microcode sequencer and the memory/peripheral bus of the CPU core.

## Interface
- `DW`, 8: accumulator/data-bus width, 8 or 16.
- `NREG`, 2: number of accumulators A0..A(NREG-1), 1..8.
- `CLK` in 1: single clock, all state updates on rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `mc_valid` in 1: microcode step present.
- `mc_op` in 5: operation code.
- `mc_r0`, `mc_r1`, `mc_r2` in 4 each: source 0, source 1, destination selectors.
- `mc_am` in 3: address mode.
- `mc_pi` in 1: increment P on acceptance.
- `mc_ack` out 1: step accepted this cycle.
- `AD` out 16: bus address. `RW` out 1: 1 = write. `DO` out DW: write data. `DI` in DW: read data.
- `mem_req` out 1: bus cycle requested. `mem_rdy` in 1: bus cycle completes this cycle.
- `vect` out 8: latched interrupt vector. `inte` out 1: interrupts enabled (= ~C[4]).
- `REG_X`, `REG_S`, `REG_P` out 16; `REG_C` out 6: debug taps.

## Operation
- Selector codes: 0 none (reads 0), 1 C, 2 X, 3 S, 4 P, 5 T, 6 E, 7 M (read: DI zero-extended; as r2: memory write), 8+k accumulator Ak; codes >= 8+NREG read 0, writes ignored.
- Address modes: 0 none, 1 P, 2 P+1, 3 S, 4 S+1, 5 X, 6 X+T, 7 E; all 16-bit, wrap mod 2^16.
- Ops: MOV(R0), ADD, ADC, SUB, SBC, AND, OR, XOR, INC, DEC, NEG, COM, PSH, PUL, BRA, LDV, INT, NOP. Unknown op = NOP (acked, no state change except `mc_pi`).
- ALU width: DW if either source or the destination is an accumulator or M, else 16. Accumulator writes truncate to DW; 16-bit sources into DW destinations truncate.
- Flags (arith/logic ops, dest != C/S/P): N = MSB, Z = result zero, V = signed overflow (logic: 0), C = carry/borrow (logic: unchanged), H = bit-3 carry when DW = 8 else unchanged; I never altered except by dest C.
- PSH: write R0 to [S], S <= S-1. PUL: read [S+1] into r2, S <= S+1.
- BRA: mc_r0 is a 6800 condition code (0 always .. F LE); if true P <= P + sext(T[7:0]) (applied after `mc_pi` increment).
- LDV: E <= {8'hFF, mc_r0, mc_r1}. INT: vect <= {mc_r0, mc_r1}.
- dest P overrides `mc_pi` increment.

## Timing
- `mem_req` = mc_valid & (mc_am != 0); `RW` = mem_req & (mc_r2 == 7); `AD`, `DO` combinational from current step and registers.
- `mc_ack` = mc_valid & (~mem_req | mem_rdy). All register, flag, S, P, vect updates commit only on rising edge with `mc_ack` = 1; a stalled step holds every register.
- Read data `DI` sampled on the edge where `mem_rdy` = 1; no read-data buffering.
- Zero-wait memory: one step per cycle, back-to-back. Wait states: step repeats unchanged until `mem_rdy`.
- Reset (RST_N low, any time incl. mid-stall): accumulators, X, S, P, T, E = 0; C = 6'b010000; vect = 0; `mc_ack`, `mem_req`, `RW` forced 0; `DO`, `AD` = 0. First step may be acked on the first edge after release.

## Structure
- Package `hd63701_exec_pkg`: op codes, selector codes, address-mode codes, condition codes, CCR bit indices, CCR reset constant.
- Sub-module `hd63701_alu_w` (parameter DW): combinational result + flag generation; the exec block holds all state, selection and handshake.

## Test plan
- Reset release: C = 6'h10, inte = 0, all regs 0; MOV code1<-code0 (C<-0) -> C = 0, inte = 1.
- DW=8 ADD A0=0x7F + A1=0x01 -> A0 = 0x80, N=1, V=1, Z=0, C=0, H=1.
- Memory read with mem_rdy low 3 cycles: MOV A0<-M at X=0x1234 -> AD = 0x1234 for 4 cycles, mc_ack only on 4th, A0 = DI then.
- PSH A1=0x5A with S=0x01FF -> write 0x5A at 0x01FF, S = 0x01FE; PUL back -> read 0x01FF, S = 0x01FF.
- BRA cond EQ, T=0xFE, P=0x1000, mc_pi=1: Z=1 -> P = 0x0FFF; Z=0 -> P = 0x1001.
- RST_N asserted during stalled write -> RW, mem_req drop immediately, S/P/regs at reset values, no write committed.
